ntt_ctrl: RTL and testbench

Sequencing controller for the Kyber NTT/INTT datapath (n = 256, q = 3329). It walks the 7 butterfly layers, one butterfly per cycle. For each butterfly it issues the coefficient-pair read addresses, the twiddle (zeta) ROM index and the CT/GS mode select to the butterfly core. It also issues the matching write-back addresses, delayed by the read + butterfly pipeline depth. It sits between the polynomial RAM/zeta ROM and the butterfly, and is the initiating side of the butterfly's `(a, b, w, mode)` interface.

---
 rtl/ntt_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ntt_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: Kyber NTT/INTT layer sequencer (n=256), one butterfly
// per cycle, with read issue and delayed write-back addressing.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, mode           begin transform; 0 = NTT (CT), 1 = INTT (GS)
//   busy, done            run in progress; one-cycle completion pulse
//   rd_en, rd_addr_a/b    coefficient pair read (j, j+len)
//   zeta_idx, bf_mode     twiddle ROM index; latched mode to butterfly
//   wr_en, wr_addr_a/b    write-back, rd_* delayed RD_LAT+BF_LAT cycles
module ntt_ctrl #(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] zeta_idx,
  output logic       bf_mode,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam int D  = RD_LAT + BF_LAT;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    lyr_q, lyr_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [DW-1:0] drn_q, drn_d;
  logic          mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lyr_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lyr_q   <= lyr_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lyr_d   = lyr_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          lyr_d   = '0;
          cnt_d   = '0;
          drn_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd127) begin
          drn_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + 1'b1;
        // Hold reads off until the layer's last write has left.
        if (drn_q == DW'(D - 1)) begin
          drn_d = '0;
          cnt_d = '0;
          if (lyr_q < 3'd6) begin
            lyr_d   = lyr_q + 3'd1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Layer geometry: len = 1 << sh, so group/offset are shift/mask.
  logic       issue;
  logic [2:0] sh;
  logic [7:0] len;
  logic [6:0] lmsk;
  logic [6:0] grp;
  logic [6:0] ofs;
  logic [7:0] a;
  logic [7:0] b;
  logic [6:0] z;

  always_comb begin
    issue = (state_q == S_ISSUE);
    sh    = mode_q ? lyr_q + 3'd1 : 3'd7 - lyr_q;
    len   = 8'd1 << sh;
    lmsk  = 7'(len - 8'd1);
    grp   = cnt_q >> sh;
    ofs   = cnt_q & lmsk;
    a     = ({1'b0, grp} << (4'd1 + {1'b0, sh}))
          | {1'b0, ofs};
    b     = a + len;
    // INTT: 256/len wraps to 0 in 7 bits at len = 2,
    // which still yields 127 - g modulo 128.
    z     = mode_q
          ? (7'd2 << (3'd7 - sh)) - 7'd1 - grp
          : (7'd1 << (3'd7 - sh)) + grp;
  end

  assign busy      = (state_q == S_ISSUE)
                   | (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign bf_mode   = mode_q;
  assign rd_en     = issue;
  assign rd_addr_a = issue ? a : '0;
  assign rd_addr_b = issue ? b : '0;
  assign zeta_idx  = issue ? z : '0;

  logic [PW-1:0] pipe_q [D];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < D; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign wr_en     = pipe_q[D-1][16];
  assign wr_addr_a = wr_en ? pipe_q[D-1][15:8] : '0;
  assign wr_addr_b = wr_en ? pipe_q[D-1][7:0] : '0;

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: scoreboard bench for ntt_ctrl, two instances
// (D = 1 and D = 3) driven by independent randomized run sequences.
module tb_ntt_ctrl;

  localparam int NK = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_w [NK];
  logic       mode_w  [NK];
  logic       busy_w  [NK];
  logic       done_w  [NK];
  logic       rde_w   [NK];
  logic       bfm_w   [NK];
  logic       wre_w   [NK];
  logic [7:0] rda_w   [NK];
  logic [7:0] rdb_w   [NK];
  logic [7:0] wra_w   [NK];
  logic [7:0] wrb_w   [NK];
  logic [6:0] zi_w    [NK];

  ntt_ctrl #(.RD_LAT(1), .BF_LAT(0)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .start(start_w[0]), .mode(mode_w[0]),
    .busy(busy_w[0]), .done(done_w[0]),
    .rd_en(rde_w[0]),
    .rd_addr_a(rda_w[0]), .rd_addr_b(rdb_w[0]),
    .zeta_idx(zi_w[0]), .bf_mode(bfm_w[0]),
    .wr_en(wre_w[0]),
    .wr_addr_a(wra_w[0]), .wr_addr_b(wrb_w[0])
  );

  ntt_ctrl #(.RD_LAT(1), .BF_LAT(2)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .start(start_w[1]), .mode(mode_w[1]),
    .busy(busy_w[1]), .done(done_w[1]),
    .rd_en(rde_w[1]),
    .rd_addr_a(rda_w[1]), .rd_addr_b(rdb_w[1]),
    .zeta_idx(zi_w[1]), .bf_mode(bfm_w[1]),
    .wr_en(wre_w[1]),
    .wr_addr_a(wra_w[1]), .wr_addr_b(wrb_w[1])
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
    int z;
  } ev_t;

  ev_t  rdq [NK][$];
  ev_t  wrq [NK][$];
  int   st_e     [NK];
  int   exp_done [NK];
  logic exp_mode [NK];
  int   rd_cnt   [NK];
  int   wr_cnt   [NK];
  int   hits     [NK][7][256];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int dk(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0d want %0d",
               nm, edge_n, act, exp);
    end
  endfunction

  // Reference: Kyber reference loop nest. An output of spec
  // cycle t is observed at the negedge where edge_n = e + t - 1,
  // e being the edge that samples start.
  function automatic void push(int k, logic m, int e);
    int   d = dk(k);
    int   zk;
    int   c;
    int   len;
    ev_t  ev;
    zk = m ? 127 : 1;
    for (int l = 0; l < 7; l++) begin
      len = m ? (2 << l) : (128 >> l);
      c = 0;
      for (int s = 0; s < 256; s += 2 * len) begin
        for (int j = s; j < s + len; j++) begin
          ev.cyc = e + l * (128 + d) + c;
          ev.a = j;
          ev.b = j + len;
          ev.z = zk;
          rdq[k].push_back(ev);
          ev.cyc = ev.cyc + d;
          ev.z = 0;
          wrq[k].push_back(ev);
          c++;
        end
        zk = m ? zk - 1 : zk + 1;
      end
    end
    st_e[k]     = e;
    exp_done[k] = e + 7 * (128 + d);
    exp_mode[k] = m;
    rd_cnt[k]   = 0;
    wr_cnt[k]   = 0;
    for (int l = 0; l < 7; l++)
      for (int x = 0; x < 256; x++)
        hits[k][l][x] = 0;
  endfunction

  function automatic void flush(int k);
    rdq[k].delete();
    wrq[k].delete();
    exp_done[k] = -1;
    st_e[k]     = 0;
  endfunction

  function automatic void mon(int k);
    string p = $sformatf("d%0d", k);
    bit    eb;
    bit    er;
    bit    ew;
    ev_t   e;
    int    l;
    int    bad;
    eb = (edge_n >= st_e[k]) && (edge_n < exp_done[k]);
    chk({p, " busy"}, busy_w[k], eb);
    chk({p, " done"}, done_w[k], edge_n == exp_done[k]);
    if (eb) chk({p, " bf_mode"}, bfm_w[k], exp_mode[k]);
    er = (rdq[k].size() > 0) && (rdq[k][0].cyc == edge_n);
    chk({p, " rd_en"}, rde_w[k], er);
    if (er) begin
      e = rdq[k].pop_front();
      if (rde_w[k]) begin
        chk({p, " rd_a"}, rda_w[k], e.a);
        chk({p, " rd_b"}, rdb_w[k], e.b);
        chk({p, " zeta"}, zi_w[k], e.z);
      end
    end
    if (rde_w[k] === 1'b1) begin
      l = rd_cnt[k] / 128;
      if (l > 6) l = 6;
      hits[k][l][rda_w[k]]++;
      hits[k][l][rdb_w[k]]++;
      rd_cnt[k]++;
    end
    ew = (wrq[k].size() > 0) && (wrq[k][0].cyc == edge_n);
    chk({p, " wr_en"}, wre_w[k], ew);
    if (ew) begin
      e = wrq[k].pop_front();
      if (wre_w[k]) begin
        chk({p, " wr_a"}, wra_w[k], e.a);
        chk({p, " wr_b"}, wrb_w[k], e.b);
      end
    end
    if (wre_w[k] === 1'b1) begin
      wr_cnt[k]++;
    end else begin
      chk({p, " wr_a idle"}, wra_w[k], 0);
      chk({p, " wr_b idle"}, wrb_w[k], 0);
    end
    if (edge_n == exp_done[k]) begin
      chk({p, " rd count"}, rd_cnt[k], 896);
      chk({p, " wr count"}, wr_cnt[k], 896);
      bad = 0;
      for (int i = 0; i < 7; i++)
        for (int x = 0; x < 256; x++)
          if (hits[k][i][x] != 1) bad++;
      chk({p, " coverage"}, bad, 0);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && edge_n > 0) begin
      for (int k = 0; k < NK; k++) mon(k);
    end
  end

  task automatic zero_chk(int k, string tag);
    string p = $sformatf("d%0d %s", k, tag);
    chk({p, " busy"}, busy_w[k], 0);
    chk({p, " done"}, done_w[k], 0);
    chk({p, " rd_en"}, rde_w[k], 0);
    chk({p, " wr_en"}, wre_w[k], 0);
    chk({p, " bf_mode"}, bfm_w[k], 0);
    chk({p, " rd_a"}, rda_w[k], 0);
    chk({p, " rd_b"}, rdb_w[k], 0);
    chk({p, " zeta"}, zi_w[k], 0);
    chk({p, " wr_a"}, wra_w[k], 0);
    chk({p, " wr_b"}, wrb_w[k], 0);
  endtask

  task automatic launch(int k, logic m);
    start_w[k] = 1'b1;
    mode_w[k]  = m;
    push(k, m, edge_n + 1);
    @(negedge clk);
    start_w[k] = 1'b0;
    mode_w[k]  = 1'($urandom);
  endtask

  // Returns at the negedge of the done cycle; optional stray
  // starts (with flipped mode) at cycles 10 and 500.
  task automatic wait_done(int k, bit gl);
    int rel;
    while (edge_n < exp_done[k]) begin
      @(negedge clk);
      rel = edge_n - st_e[k] + 1;
      if (gl && (rel == 10 || rel == 500)) begin
        start_w[k] = 1'b1;
        mode_w[k]  = ~exp_mode[k];
      end else begin
        start_w[k] = 1'b0;
      end
    end
  endtask

  task automatic seq(int k);
    repeat ($urandom_range(1, 6)) @(negedge clk);
    launch(k, 1'b0);
    wait_done(k, 1'b0);
    start_w[k] = 1'b1;
    @(negedge clk);
    launch(k, 1'b1);
    wait_done(k, 1'b1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    launch(k, 1'($urandom));
    wait_done(k, 1'($urandom));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NK; k++) begin
      start_w[k]  = 1'b0;
      mode_w[k]   = 1'b0;
      exp_done[k] = -1;
      st_e[k]     = 0;
      rd_cnt[k]   = 0;
      wr_cnt[k]   = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NK; k++) zero_chk(k, "reset");
    rst_n = 1'b1;

    fork
      seq(0);
      seq(1);
    join

    @(negedge clk);
    fork
      launch(0, 1'($urandom));
      launch(1, 1'($urandom));
    join
    while (edge_n < st_e[0] + 299) @(negedge clk);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < NK; k++) flush(k);
    @(negedge clk);
    for (int k = 0; k < NK; k++) zero_chk(k, "midrst");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    fork
      begin
        launch(0, 1'($urandom));
        wait_done(0, 1'b0);
      end
      begin
        launch(1, 1'($urandom));
        wait_done(1, 1'b0);
      end
    join
    repeat (5) @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("d%0d rdq left", k), rdq[k].size(), 0);
      chk($sformatf("d%0d wrq left", k), wrq[k].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
